host_dma_ctrl: RTL and testbench

HOST_DMA_CTRL -- requirements
Module: host_dma_ctrl

---
 rtl/host_dma_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_host_dma_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_dma_ctrl.sv
// Host DMA controller: streams operand A, B and opcode buffers into processor BRAMs,
// starts the run, then streams the result BRAM back. Optional macro: HOST_DMA_CHECKSUM_EN.
module host_dma_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [ADDR_WIDTH-1:0] addr_data_o,
  output logic                  ena_data_a_o,
  output logic                  wea_data_a_o,
  output logic                  ena_data_b_o,
  output logic                  wea_data_b_o,
  output logic                  ena_data_result_o,
  output logic                  wea_data_result_o,
  output logic [OP_WIDTH-1:0]   op_o,
  output logic [ADDR_WIDTH-1:0] addr_op_o,
  output logic                  ena_op_o,
  output logic                  wea_op_o,
  output logic                  start_o,
  input  logic                  done_i,
  input  logic [DATA_WIDTH-1:0] result_i,
  output logic                  busy_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD_A  = 3'd1;
  localparam logic [2:0] LOAD_B  = 3'd2;
  localparam logic [2:0] LOAD_OP = 3'd3;
  localparam logic [2:0] RUN     = 3'd4;
  localparam logic [2:0] RELEASE = 3'd5;
  localparam logic [2:0] READ    = 3'd6;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
`ifdef HOST_DMA_CHECKSUM_EN
  // One extra emitted word (the checksum) needs one more bit of emit count.
  localparam int EW = ADDR_WIDTH + 1;
  localparam logic [EW-1:0] LAST_EMIT = {1'b1, {ADDR_WIDTH{1'b0}}};
`else
  localparam int EW = ADDR_WIDTH;
  localparam logic [EW-1:0] LAST_EMIT = '1;
`endif

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic                  rd_done_q, rd_done_d;
  logic                  inflight_q, inflight_d;
  logic [EW-1:0]         emit_q, emit_d;
  logic [DATA_WIDTH-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic                  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]            fcnt_q, fcnt_d;
`ifdef HOST_DMA_CHECKSUM_EN
  logic [31:0]           sum_q, sum_d;
  logic                  csum_phase;
`endif

  logic                  fifo_pop;
  logic                  fifo_push;
  logic                  m_pop;
  logic [1:0]            slots;
  logic [DATA_WIDTH-1:0] head;

  assign head      = rptr_q ? mem1_q : mem0_q;
  assign fifo_pop  = (fcnt_q != 2'd0) && m_ready_i;
  assign fifo_push = inflight_q;
  // A pop this cycle frees its slot in time for the issue, giving one word per cycle.
  assign slots     = fcnt_q + {1'b0, inflight_q} - {1'b0, fifo_pop};
  assign busy_o    = (state_q != IDLE);

`ifdef HOST_DMA_CHECKSUM_EN
  assign csum_phase = (state_q == READ) && (emit_q == LAST_EMIT);
  assign m_valid_o  = (fcnt_q != 2'd0) || csum_phase;
  assign m_data_o   = csum_phase ? DATA_WIDTH'(sum_q) :
                      ((fcnt_q != 2'd0) ? head : '0);
`else
  assign m_valid_o  = (fcnt_q != 2'd0);
  assign m_data_o   = m_valid_o ? head : '0;
`endif
  assign m_pop = m_valid_o && m_ready_i;

  always_comb begin
    state_d           = state_q;
    wcnt_d            = wcnt_q;
    rd_cnt_d          = rd_cnt_q;
    rd_done_d         = rd_done_q;
    inflight_d        = 1'b0;
    emit_d            = emit_q;
    mem0_d            = mem0_q;
    mem1_d            = mem1_q;
    wptr_d            = wptr_q;
    rptr_d            = rptr_q;
    fcnt_d            = fcnt_q;
`ifdef HOST_DMA_CHECKSUM_EN
    sum_d             = sum_q;
`endif
    s_ready_o         = 1'b0;
    data_o            = '0;
    addr_data_o       = '0;
    op_o              = '0;
    addr_op_o         = '0;
    ena_data_a_o      = 1'b0;
    wea_data_a_o      = 1'b0;
    ena_data_b_o      = 1'b0;
    wea_data_b_o      = 1'b0;
    ena_data_result_o = 1'b0;
    wea_data_result_o = 1'b0;
    ena_op_o          = 1'b0;
    wea_op_o          = 1'b0;
    start_o           = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_valid_i) state_d = LOAD_A;
      end
      LOAD_A, LOAD_B, LOAD_OP: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          wcnt_d = wcnt_q + ADDR_WIDTH'(1);
          case (state_q)
            LOAD_A: begin
              ena_data_a_o = 1'b1;
              wea_data_a_o = 1'b1;
              data_o       = s_data_i;
              addr_data_o  = wcnt_q;
              if (wcnt_q == LAST_ADDR) state_d = LOAD_B;
            end
            LOAD_B: begin
              ena_data_b_o = 1'b1;
              wea_data_b_o = 1'b1;
              data_o       = s_data_i;
              addr_data_o  = wcnt_q;
              if (wcnt_q == LAST_ADDR) state_d = LOAD_OP;
            end
            default: begin
              ena_op_o  = 1'b1;
              wea_op_o  = 1'b1;
              op_o      = s_data_i[OP_WIDTH-1:0];
              addr_op_o = wcnt_q;
              if (wcnt_q == LAST_ADDR) state_d = RUN;
            end
          endcase
        end
      end
      RUN: begin
        start_o = 1'b1;
        if (done_i) state_d = RELEASE;
      end
      RELEASE: begin
        if (!done_i) begin
          state_d   = READ;
          rd_cnt_d  = '0;
          rd_done_d = 1'b0;
          emit_d    = '0;
`ifdef HOST_DMA_CHECKSUM_EN
          sum_d     = '0;
`endif
        end
      end
      READ: begin
        if (!rd_done_q && (slots < 2'd2)) begin
          ena_data_result_o = 1'b1;
          addr_data_o       = rd_cnt_q;
          inflight_d        = 1'b1;
          rd_cnt_d          = rd_cnt_q + ADDR_WIDTH'(1);
          if (rd_cnt_q == LAST_ADDR) rd_done_d = 1'b1;
        end
        if (m_pop) begin
          emit_d = emit_q + EW'(1);
          if (emit_q == LAST_EMIT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Result BRAM data arrives one cycle after the read strobe.
    if (fifo_push) begin
      if (wptr_q) mem1_d = result_i;
      else        mem0_d = result_i;
      wptr_d = ~wptr_q;
    end
    if (fifo_pop) begin
      rptr_d = ~rptr_q;
`ifdef HOST_DMA_CHECKSUM_EN
      sum_d  = sum_q + 32'(head);
`endif
    end
    fcnt_d = fcnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      rd_cnt_q   <= '0;
      rd_done_q  <= 1'b0;
      inflight_q <= 1'b0;
      emit_q     <= '0;
      mem0_q     <= '0;
      mem1_q     <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      fcnt_q     <= '0;
`ifdef HOST_DMA_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_done_q  <= rd_done_d;
      inflight_q <= inflight_d;
      emit_q     <= emit_d;
      mem0_q     <= mem0_d;
      mem1_q     <= mem1_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fcnt_q     <= fcnt_d;
`ifdef HOST_DMA_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_host_dma_ctrl.sv
// Directed bench for host_dma_ctrl: load with gap, run handshake, streaming reads,
// random back-pressure, mid-load reset. Honours HOST_DMA_CHECKSUM_EN.
module tb_host_dma_ctrl;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int OW = 3;
  localparam int N  = 1 << AW;
`ifdef HOST_DMA_CHECKSUM_EN
  localparam int TOTAL = N + 1;
`else
  localparam int TOTAL = N;
`endif
  localparam logic [DW-1:0] CSUM = 32'h0017FA00;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] s_data_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [DW-1:0] data_o;
  logic [AW-1:0] addr_data_o;
  logic          ena_data_a_o, wea_data_a_o, ena_data_b_o, wea_data_b_o;
  logic          ena_data_result_o, wea_data_result_o;
  logic [OW-1:0] op_o;
  logic [AW-1:0] addr_op_o;
  logic          ena_op_o, wea_op_o;
  logic          start_o;
  logic          done_i;
  logic [DW-1:0] result_i;
  logic          busy_o;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] memA [N];
  logic [DW-1:0] memB [N];

  wire [7:0] strobes = {ena_data_a_o, wea_data_a_o, ena_data_b_o, wea_data_b_o,
                        ena_data_result_o, wea_data_result_o, ena_op_o, wea_op_o};

  host_dma_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OP_WIDTH(OW)) dut (
    .CLK(CLK), .RST(RST),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .data_o(data_o), .addr_data_o(addr_data_o),
    .ena_data_a_o(ena_data_a_o), .wea_data_a_o(wea_data_a_o),
    .ena_data_b_o(ena_data_b_o), .wea_data_b_o(wea_data_b_o),
    .ena_data_result_o(ena_data_result_o), .wea_data_result_o(wea_data_result_o),
    .op_o(op_o), .addr_op_o(addr_op_o), .ena_op_o(ena_op_o), .wea_op_o(wea_op_o),
    .start_o(start_o), .done_i(done_i), .result_i(result_i), .busy_o(busy_o)
  );

  always #5 CLK = ~CLK;

  // Processor model: result BRAM returns A+B one cycle after the read strobe.
  initial begin
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    result_i = '0;
    forever begin
      @(negedge CLK);
      #3;
      rd_en   = ena_data_result_o;
      rd_addr = addr_data_o;
      @(posedge CLK);
      #1;
      result_i = rd_en ? (memA[rd_addr] + memB[rd_addr]) : 32'hDEADBEEF;
    end
  end

  task automatic test_reset();
    RST = 1'b0; s_valid_i = 1'b1; s_data_i = 32'h5A5A5A5A; done_i = 1'b1; m_ready_i = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if ({s_ready_o, m_valid_o, m_data_o, start_o, busy_o, strobes, data_o, addr_data_o,
         op_o, addr_op_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got strobes=%h data=%h addr=%h busy=%b ready=%b want all 0",
               strobes, data_o, addr_data_o, busy_o, s_ready_o);
    end
    @(negedge CLK);
    s_valid_i = 1'b0; done_i = 1'b0; m_ready_i = 1'b0; RST = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || s_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b ready=%b want 0 0", busy_o, s_ready_o);
    end
  endtask

  task automatic load_all(input int gap_b, input int rst_b, input string tag);
    int bad [3];
    int gap_bad;
    int once_bad;
    int wcnt_b [N];
    logic [7:0]    exp_s;
    logic [DW-1:0] w;
    bad = '{0, 0, 0}; gap_bad = 0; once_bad = 0;
    foreach (wcnt_b[k]) wcnt_b[k] = 0;
    @(negedge CLK);
    s_valid_i = 1'b1; s_data_i = '0;
    #1;
    checks++;
    if (s_ready_o !== 1'b0 || strobes !== 8'h00) begin
      errors++;
      $display("FAIL %s idle_no_accept: got ready=%b strobes=%h want 0 00", tag, s_ready_o, strobes);
    end
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < N; i++) begin
        if (b == 1 && i == gap_b) begin
          for (int g = 0; g < 5; g++) begin
            @(negedge CLK);
            s_valid_i = 1'b0;
            #1;
            if (strobes !== 8'h00 || s_ready_o !== 1'b1) gap_bad++;
          end
        end
        @(negedge CLK);
        s_valid_i = 1'b1;
        w = (b == 0) ? DW'(i) : ((b == 1) ? DW'(2 * i) : '0);
        s_data_i = w;
        if (b == 1 && i == rst_b) begin
          #1;
          RST = 1'b0;
          #1;
          checks++;
          if ({s_ready_o, m_valid_o, m_data_o, start_o, busy_o, strobes, data_o, addr_data_o,
               op_o, addr_op_o} !== '0) begin
            errors++;
            $display("FAIL %s reset_mid_load: got strobes=%h data=%h addr=%h busy=%b ready=%b want all 0",
                     tag, strobes, data_o, addr_data_o, busy_o, s_ready_o);
          end
          @(negedge CLK);
          RST = 1'b1; s_valid_i = 1'b0;
          #1;
          checks++;
          if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after_mid_reset: got busy=%b want 0", tag, busy_o);
          end
          return;
        end
        #1;
        exp_s = (b == 0) ? 8'hC0 : ((b == 1) ? 8'h30 : 8'h03);
        if (strobes !== exp_s || start_o !== 1'b0) bad[b]++;
        else if (b < 2 && (addr_data_o !== AW'(i) || data_o !== w)) bad[b]++;
        else if (b == 2 && (addr_op_o !== AW'(i) || op_o !== 3'd0)) bad[b]++;
        if (b == 0 && strobes[7]) memA[addr_data_o] = data_o;
        if (b == 1 && strobes[5]) begin
          memB[addr_data_o] = data_o;
          wcnt_b[addr_data_o]++;
        end
      end
    end
    @(negedge CLK);
    s_valid_i = 1'b0;
    #1;
    for (int b = 0; b < 3; b++) begin
      checks++;
      if (bad[b] != 0) begin
        errors++;
        $display("FAIL %s load_buf%0d: got %0d bad write cycles want 0", tag, b, bad[b]);
      end
    end
    foreach (wcnt_b[k]) if (wcnt_b[k] != 1) once_bad++;
    checks++;
    if (once_bad != 0) begin
      errors++;
      $display("FAIL %s b_written_once: got %0d addresses not written exactly once want 0", tag, once_bad);
    end
    if (gap_b >= 0) begin
      checks++;
      if (gap_bad != 0 || wcnt_b[gap_b] != 1) begin
        errors++;
        $display("FAIL %s gap: got gap_bad=%0d writes@%0d=%0d want 0 and 1", tag, gap_bad, gap_b, wcnt_b[gap_b]);
      end
    end
    checks++;
    if (start_o !== 1'b1 || busy_o !== 1'b1 || s_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL %s start_after_load: got start=%b busy=%b ready=%b want 1 1 0", tag, start_o, busy_o, s_ready_o);
    end
  endtask

  task automatic run_phase(input int delay);
    int hold_bad = 0;
    int rel_bad  = 0;
    for (int k = 1; k <= delay; k++) begin
      @(negedge CLK);
      if (k == delay) done_i = 1'b1;
      #1;
      if (start_o !== 1'b1) hold_bad++;
    end
    checks++;
    if (hold_bad != 0) begin
      errors++;
      $display("FAIL start_hold: got %0d cycles with start low want 0", hold_bad);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (start_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL start_fall: got start=%b busy=%b want 0 1", start_o, busy_o);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      #1;
      if (ena_data_result_o !== 1'b0 || m_valid_o !== 1'b0 || start_o !== 1'b0) rel_bad++;
    end
    @(negedge CLK);
    done_i = 1'b0;
    #1;
    if (ena_data_result_o !== 1'b0) rel_bad++;
    checks++;
    if (rel_bad != 0) begin
      errors++;
      $display("FAIL release_wait: got %0d early read cycles want 0", rel_bad);
    end
  endtask

  task automatic read_phase(input bit rnd, input string tag);
    int got = 0, bad = 0, bubbles = 0, iss = 0, iss_bad = 0, cyc = 0;
    bit started = 1'b0;
    logic first_ena = 1'b0;
    logic [DW-1:0] expv;
    logic [DW-1:0] last_word = '0;
    while (got < TOTAL && cyc < 6000) begin
      @(negedge CLK);
      m_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (cyc == 0) first_ena = ena_data_result_o;
      if (wea_data_result_o !== 1'b0) iss_bad++;
      if (ena_data_result_o === 1'b1) begin
        if (iss >= N || addr_data_o !== AW'(iss)) iss_bad++;
        iss++;
      end
      if (m_valid_o === 1'b1) begin
        started = 1'b1;
        if (m_ready_i) begin
          expv = (got < N) ? DW'(3 * got) : CSUM;
          if (m_data_o !== expv) bad++;
          last_word = m_data_o;
          got++;
        end
      end else if (started && !rnd) begin
        bubbles++;
      end
      cyc++;
    end
    @(negedge CLK);
    m_ready_i = 1'b0;
    #1;
    checks++;
    if (first_ena !== 1'b1) begin
      errors++;
      $display("FAIL %s read_first_issue: got ena=%b want 1", tag, first_ena);
    end
    checks++;
    if (got != TOTAL) begin
      errors++;
      $display("FAIL %s word_count: got %0d want %0d", tag, got, TOTAL);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s word_values: got %0d wrong words want 0", tag, bad);
    end
    checks++;
    if (iss != N || iss_bad != 0) begin
      errors++;
      $display("FAIL %s read_issue: got %0d issues (%0d bad) want %0d (0 bad)", tag, iss, iss_bad, N);
    end
    if (!rnd) begin
      checks++;
      if (bubbles != 0) begin
        errors++;
        $display("FAIL %s bubbles: got %0d want 0", tag, bubbles);
      end
    end
`ifdef HOST_DMA_CHECKSUM_EN
    checks++;
    if (last_word !== CSUM) begin
      errors++;
      $display("FAIL %s checksum_word: got %h want %h", tag, last_word, CSUM);
    end
`endif
    checks++;
    if (busy_o !== 1'b0 || m_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s read_exit_idle: got busy=%b m_valid=%b want 0 0", tag, busy_o, m_valid_o);
    end
  endtask

  task automatic test_load_gap();
    load_all(500, -1, "gap");
  endtask

  task automatic test_run();
    run_phase(1030);
  endtask

  task automatic test_read_steady();
    read_phase(1'b0, "steady");
  endtask

  task automatic test_reset_mid_load();
    load_all(-1, 200, "midreset");
  endtask

  task automatic test_back_to_back();
    load_all(-1, -1, "reload");
    run_phase(40);
    read_phase(1'b1, "random");
  endtask

  initial begin
    s_valid_i = 1'b0; s_data_i = '0; m_ready_i = 1'b0; done_i = 1'b0;
    test_reset();
    test_load_gap();
    test_run();
    test_read_steady();
    test_reset_mid_load();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
